// File: rtl/iq_tx_framer.sv
// iq_tx_framer: buffers I/Q samples and paces them onto serializer frame slots,
// one sample per (cfg_skip+2) slots, with zero, end and underrun frames.
module iq_tx_framer #(
  parameter int SAMPLE_W   = 13,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          slot_strobe,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [SAMPLE_W-1:0]           s_i,
  input  logic [SAMPLE_W-1:0]           s_q,
  input  logic                          s_last,
  input  logic                          start,
  input  logic                          abort,
  input  logic [DIV_W-1:0]              cfg_skip,
  input  logic                          cfg_cw,
  output logic [31:0]                   tx_data,
  output logic                          busy,
  output logic                          done,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] END_FRAME = 32'h8000_4000;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_TAIL} state_t;
  state_t state;
  logic [2*SAMPLE_W:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DIV_W-1:0] cnt, skip_l;
  logic start_pending, abort_pending, last_l;
  logic push, pop, empty, ab, at_sample;
  logic hlast;
  logic [SAMPLE_W-1:0] hi, hq;
  logic [12:0] i13, q13;
  logic [31:0] frame;
  assign {hlast, hi, hq} = mem[rd_ptr];
  assign empty     = fifo_level == '0;
  assign s_ready   = !fifo_level[AW];
  assign push      = s_valid && s_ready;
  assign ab        = abort_pending || abort;
  assign at_sample = state == S_WAIT && !ab && cnt == skip_l;
  assign pop       = slot_strobe && at_sample && !empty;
  assign busy      = state != S_IDLE;
  // samples are left-justified into the 13-bit rails
  assign i13   = cfg_cw ? 13'h0fff : 13'(hi) << (13 - SAMPLE_W);
  assign q13   = cfg_cw ? 13'h0fff : 13'(hq) << (13 - SAMPLE_W);
  assign frame = empty ? 32'h8001_4000 : {2'b10, i13, 1'b1, 2'b01, q13, 1'b0};
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {s_last, s_i, s_q};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      fifo_level <= fifo_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state         <= S_IDLE;
      tx_data       <= '0;
      done          <= 1'b0;
      underrun      <= 1'b0;
      start_pending <= 1'b0;
      abort_pending <= 1'b0;
      cnt           <= '0;
      skip_l        <= '0;
      last_l        <= 1'b0;
      rd_ptr        <= '0;
    end else begin
      done <= 1'b0;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (state == S_IDLE && start) begin
        start_pending <= 1'b1;
        underrun      <= 1'b0;
      end
      if (abort && (state == S_WAIT || state == S_SEND)) abort_pending <= 1'b1;
      if (slot_strobe)
        case (state)
          S_IDLE: begin
            tx_data <= '0;
            if (start_pending) begin
              cnt           <= '0;
              skip_l        <= cfg_skip;
              start_pending <= 1'b0;
              state         <= S_WAIT;
            end
          end
          S_WAIT:
            if (ab) begin
              tx_data       <= END_FRAME;
              abort_pending <= 1'b0;
              state         <= S_TAIL;
            end else if (at_sample) begin
              tx_data <= frame;
              last_l  <= !empty && hlast;
              if (empty) underrun <= 1'b1;
              state   <= S_SEND;
            end else begin
              cnt     <= cnt + 1'b1;
              tx_data <= '0;
            end
          S_SEND:
            if (ab || last_l) begin
              tx_data       <= END_FRAME;
              abort_pending <= 1'b0;
              state         <= S_TAIL;
            end else begin
              tx_data <= '0;
              cnt     <= '0;
              state   <= S_WAIT;
            end
          default: begin
            tx_data       <= '0;
            done          <= 1'b1;
            abort_pending <= 1'b0;
            state         <= S_IDLE;
          end
        endcase
    end
endmodule
